// File: rtl/dht22_pkg.sv
// DHT22 reader shared types and helpers.
// FSM states, error codes, frame size and decode functions.
package dht22_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_NORESP = 2'd1;
  localparam logic [1:0] ERR_BIT    = 2'd2;
  localparam logic [1:0] ERR_CSUM   = 2'd3;

  localparam int FRAME_BITS = 40;
  localparam int CNT_W      = 21;

  // Sign-magnitude sensor word to two's complement.
  function automatic logic [15:0] dht_temp(
    input logic [15:0] w
  );
    logic [15:0] mag;
    mag = {1'b0, w[14:0]};
    return w[15] ? (~mag + 16'd1) : mag;
  endfunction

  // Wrap-around sum of the four data bytes.
  function automatic logic [7:0] dht_sum(
    input logic [FRAME_BITS-1:0] f
  );
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/dht22_us_tick.sv
// Microsecond tick prescaler.
// Emits a one-cycle pulse every CLKS_PER_US clocks.
module dht22_us_tick #(
  parameter int CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic us_tick
);

  localparam int W =
    (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Next count and tick.
  always_comb begin
    cnt_d  = cnt_q + W'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign us_tick = tick_q;

endmodule

// File: rtl/dht22_read_ctrl.sv
// DHT22 single-wire read sequencer.
// Start pulse, response timing, 40-bit decode, checksum, holdoff.
module dht22_read_ctrl
  import dht22_pkg::*;
#(
  parameter int CLKS_PER_US   = 100,
  parameter int START_LOW_US  = 1100,
  parameter int BIT_THRESH_US = 48,
  parameter int TIMEOUT_US    = 200,
  parameter int HOLDOFF_US    = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        dht_in,
  output logic        dht_drive_low,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [1:0]  err,
  output logic [15:0] humidity,
  output logic [15:0] temperature
);

  localparam logic [CNT_W-1:0] START_C = CNT_W'(START_LOW_US);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(BIT_THRESH_US);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLDOFF_US);
  localparam logic [5:0]       LAST_B  = 6'(FRAME_BITS - 1);

  logic us_tick;

  dht22_us_tick #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .us_tick(us_tick)
  );

  logic [1:0] sync_q;
  logic       prev_q;
  logic       fall, rise;

  // Pin synchronizer plus edge history; idles high like the pull-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dht_in};
      prev_q <= sync_q[1];
    end
  end

  assign fall = prev_q & ~sync_q[1];
  assign rise = ~prev_q & sync_q[1];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      us_cnt_q, us_cnt_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                  hold_act_q, hold_act_d;
  logic                  pend_q, pend_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic                  drive_q, drive_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [1:0]            err_q, err_d;
  logic [15:0]           hum_q, hum_d;
  logic [15:0]           temp_q, temp_d;
  logic                  tmo, fin;
  logic [1:0]            fin_err;

  assign tmo = (us_cnt_q >= TMO_C);

  // Next-state, holdoff, decode and result logic.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    hold_act_d = hold_act_q;
    pend_d     = pend_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    err_d      = err_q;
    hum_d      = hum_q;
    temp_d     = temp_q;
    fin        = 1'b0;
    fin_err    = ERR_NONE;

    if (hold_act_q) begin
      if (hold_cnt_q >= HOLD_C) begin
        hold_act_d = 1'b0;
      end else if (us_tick) begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req || pend_q) begin
          if (!hold_act_q) begin
            state_d   = START_LOW;
            busy_d    = 1'b1;
            pend_d    = 1'b0;
            bit_idx_d = '0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      START_LOW: begin
        if (us_cnt_q >= START_C) state_d = RELEASE;
      end
      RELEASE: begin
        if (fall) begin
          state_d = RESP_LOW;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = ERR_NORESP;
        end
      end
      RESP_LOW: begin
        if (rise) begin
          state_d = RESP_HIGH;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = ERR_NORESP;
        end
      end
      RESP_HIGH: begin
        if (fall) begin
          state_d = BIT_LOW;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = ERR_NORESP;
        end
      end
      BIT_LOW: begin
        if (rise) begin
          state_d = BIT_HIGH;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = ERR_BIT;
        end
      end
      BIT_HIGH: begin
        if (fall) begin
          data_d    = {data_q[FRAME_BITS-2:0],
                       (us_cnt_q > THR_C)};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == LAST_B) ? CHECK : BIT_LOW;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = ERR_BIT;
        end
      end
      CHECK: begin
        fin = 1'b1;
        if (dht_sum(data_q) == data_q[7:0]) begin
          valid_d = 1'b1;
          hum_d   = data_q[39:24];
          temp_d  = dht_temp(data_q[23:8]);
        end else begin
          fin_err = ERR_CSUM;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      err_d      = fin_err;
      hold_act_d = 1'b1;
      hold_cnt_d = '0;
      if (fin_err != ERR_NONE) valid_d = 1'b0;
    end

    if (state_d != state_q) begin
      us_cnt_d = '0;
    end else if (us_tick && (us_cnt_q != '1)) begin
      us_cnt_d = us_cnt_q + CNT_W'(1);
    end else begin
      us_cnt_d = us_cnt_q;
    end

    drive_d = (state_d == START_LOW);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      us_cnt_q   <= '0;
      hold_cnt_q <= '0;
      hold_act_q <= 1'b0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      bit_idx_q  <= '0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= ERR_NONE;
      hum_q      <= '0;
      temp_q     <= '0;
    end else begin
      state_q    <= state_d;
      us_cnt_q   <= us_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      hold_act_q <= hold_act_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      hum_q      <= hum_d;
      temp_q     <= temp_d;
    end
  end

  assign dht_drive_low = drive_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign valid         = valid_q;
  assign err           = err_q;
  assign humidity      = hum_q;
  assign temperature   = temp_q;

endmodule

// File: tb/tb_dht22_read_ctrl.sv
// Scoreboard bench for dht22_read_ctrl.
// Sensor model on the pin; monitor checks every done.
module tb_dht22_read_ctrl;

  localparam int CPU   = 2;
  localparam int CLK_P = 10;
  localparam int US    = CPU * CLK_P;
  localparam int HOLD  = 50;

  localparam logic [39:0] F_GOOD = 40'h028C015FEE;
  localparam logic [39:0] F_NEG  = 40'h0190806576;
  localparam logic [39:0] F_BAD  = 40'h028C015FEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        pin;
  logic        dht_in;
  logic        dht_drive_low;
  logic        busy;
  logic        done;
  logic        valid;
  logic [1:0]  err;
  logic [15:0] humidity;
  logic [15:0] temperature;

  assign dht_in = dht_drive_low ? 1'b0 : pin;

  always #(CLK_P / 2) clk = ~clk;

  dht22_read_ctrl #(
    .CLKS_PER_US  (CPU),
    .START_LOW_US (20),
    .BIT_THRESH_US(48),
    .TIMEOUT_US   (200),
    .HOLDOFF_US   (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .dht_in       (dht_in),
    .dht_drive_low(dht_drive_low),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .err          (err),
    .humidity     (humidity),
    .temperature  (temperature)
  );

  typedef struct {
    logic        v;
    logic [1:0]  e;
    logic [15:0] h;
    logic [15:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act,
                         input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic push(input logic v, input logic [1:0] e,
                      input logic [15:0] h, input logic [15:0] t);
    exp_t x;
    x.v = v;
    x.e = e;
    x.h = h;
    x.t = t;
    exp_q.push_back(x);
  endtask

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t x;
      done_cnt++;
      if (exp_q.size() == 0) begin
        fail("unexpected_done");
      end else begin
        x = exp_q.pop_front();
        chk("sb_valid", 32'(valid), 32'(x.v));
        chk("sb_err", 32'(err), 32'(x.e));
        chk("sb_humidity", 32'(humidity), 32'(x.h));
        chk("sb_temperature", 32'(temperature), 32'(x.t));
      end
    end
  end

  task automatic wait_drive(input logic lvl, input int max_us,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_us * CPU; i++) begin
      @(negedge clk);
      if (dht_drive_low == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max_us, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_us * CPU; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Sensor reply; stop_bit >= 0 abandons the frame in that bit's high.
  task automatic sensor(input logic [39:0] f, input int stop_bit);
    bit ok;
    wait_drive(1'b1, 100, ok);
    if (!ok) begin
      fail("sensor_start_seen");
      return;
    end
    wait_drive(1'b0, 100, ok);
    if (!ok) begin
      fail("sensor_release_seen");
      return;
    end
    #(20 * US) pin = 1'b0;
    #(40 * US) pin = 1'b1;
    #(40 * US);
    for (int i = 0; i < 40; i++) begin
      pin = 1'b0;
      #(20 * US) pin = 1'b1;
      if (i == stop_bit) begin
        #(10 * US);
        return;
      end
      #((f[39-i] ? 70 : 20) * US);
    end
    pin = 1'b0;
    #(20 * US) pin = 1'b1;
  endtask

  task automatic do_read(input logic [39:0] f, input string nm);
    int d0;
    bit ok;
    d0 = done_cnt;
    pulse_req();
    chk({nm, "_busy_on_req"}, 32'(busy), 32'd1);
    fork
      sensor(f, -1);
      begin
        wait_done(4000, ok);
        if (!ok) fail({nm, "_done_seen"});
      end
    join
    #(60 * US);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    longint t_rel, t_done, t_start;
    bit     ok;
    int     d0;

    rst_n = 1'b0;
    req   = 1'b0;
    pin   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_drive", 32'(dht_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hum", 32'(humidity), 32'd0);
    chk("rst_temp", 32'(temperature), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    push(1'b1, 2'd0, 16'd652, 16'd351);
    do_read(F_GOOD, "good");

    push(1'b1, 2'd0, 16'd400, 16'hFF9B);
    do_read(F_NEG, "neg");

    push(1'b0, 2'd3, 16'd400, 16'hFF9B);
    do_read(F_BAD, "csum");

    // No sensor: pin stays high after release.
    push(1'b0, 2'd1, 16'd400, 16'hFF9B);
    pulse_req();
    wait_drive(1'b0, 100, ok);
    if (!ok) fail("nosens_release");
    t_rel = $time;
    wait_done(400, ok);
    if (!ok) fail("nosens_done");
    t_done = $time;
    chk_rng("nosens_done_delay", t_done - t_rel,
            199 * US, 201 * US);
    @(negedge clk);
    chk("nosens_busy_low", 32'(busy), 32'd0);

    // Holdoff: req 10us after done waits for holdoff.
    #(10 * US);
    push(1'b1, 2'd0, 16'd652, 16'd351);
    d0 = done_cnt;
    pulse_req();
    chk("hold_pending_busy", 32'(busy), 32'd0);
    wait_drive(1'b1, 100, ok);
    if (!ok) fail("hold_start");
    t_start = $time;
    chk_rng("hold_start_delay", t_start - t_done,
            (HOLD - 1) * US, (HOLD + 2) * US);
    pulse_req();
    fork
      sensor(F_GOOD, -1);
      begin
        wait_done(4000, ok);
        if (!ok) fail("hold_done_seen");
      end
    join
    #(200 * US);
    chk("hold_second_req_dropped", 32'(done_cnt - d0), 32'd1);
    chk("hold_idle_after", 32'(busy), 32'd0);

    // Reset in the high phase of bit 20.
    d0 = done_cnt;
    pulse_req();
    sensor(F_GOOD, 20);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_drive", 32'(dht_drive_low), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_hum", 32'(humidity), 32'd0);
    chk("mid_rst_temp", 32'(temperature), 32'd0);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(1'b1, 2'd0, 16'd652, 16'd351);
    do_read(F_GOOD, "fresh");

    chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
